// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv window engine and its input arbiter.
package conv_pkg;

    typedef logic [7:0] pixel_t;

    localparam int unsigned CONV_FRAME_H = 64;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/conv_rr_pick.sv
// Rotating priority encoder: first asserted request at or after i_ptr, wrapping.
module conv_rr_pick #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            w_cand = ID_W'((32'(i_ptr) + k) % N_SRC);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/conv_frame_arb.sv
// Frame-granular round-robin arbiter sharing one conv engine between N_SRC
// AXI-Stream pixel sources; grant held from SOF until FRAME_H lines accepted.
module conv_frame_arb
    import conv_pkg::*;
#(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned FRAME_H = CONV_FRAME_H,
    parameter int unsigned ID_W    = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [N_SRC-1:0] s_tvalid_i,
    input  pixel_t           s_tdata_i [N_SRC],
    input  logic [N_SRC-1:0] s_tlast_i,
    input  logic [N_SRC-1:0] s_tuser_i,
    output logic [N_SRC-1:0] s_tready_o,
    output logic             m_tvalid_o,
    output pixel_t           m_tdata_o,
    output logic             m_tlast_o,
    output logic             m_tuser_o,
    input  logic             m_tready_i,
    output logic [ID_W-1:0]  m_tid_o,
    output logic             busy_o,
    output logic             drop_o,
    output logic             err_sof_o
);

    localparam int unsigned LCW = $clog2(FRAME_H + 1);

    arb_state_t      r_state;
    logic [ID_W-1:0] r_gnt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [LCW-1:0]  r_line;
    logic            r_first;
    logic            r_act;
    logic            r_drop;
    logic            r_err;

    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_drop_vec;
    logic             w_found;
    logic [ID_W-1:0]  w_pick;
    logic             w_busy;
    logic             w_sel_valid;
    logic             w_fire;

    // r_act keeps every ready/request low while reset is held.
    assign w_busy      = (r_state == ARB_GRANT);
    assign w_req       = s_tvalid_i &  s_tuser_i & {N_SRC{r_act}};
    assign w_drop_vec  = s_tvalid_i & ~s_tuser_i & {N_SRC{r_act}};
    assign w_sel_valid = s_tvalid_i[r_gnt];
    assign w_fire      = w_busy & w_sel_valid & m_tready_i;

    conv_rr_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_comb begin
        s_tready_o = '0;
        if (w_busy) begin
            s_tready_o[r_gnt] = m_tready_i;
        end else begin
            s_tready_o = w_drop_vec;
        end
    end

    assign m_tvalid_o = w_busy & w_sel_valid;
    assign m_tdata_o  = w_busy ? s_tdata_i[r_gnt] : '0;
    assign m_tlast_o  = w_busy & s_tlast_i[r_gnt];
    assign m_tuser_o  = w_busy & s_tuser_i[r_gnt];
    assign m_tid_o    = r_gnt;
    assign busy_o     = w_busy;
    assign drop_o     = r_drop;
    assign err_sof_o  = r_err;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= ARB_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
            r_line   <= '0;
            r_first  <= 1'b1;
            r_act    <= 1'b0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_act  <= 1'b1;
            r_drop <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_drop <= |w_drop_vec;
                    if (w_found) begin
                        r_gnt   <= w_pick;
                        r_line  <= '0;
                        r_first <= 1'b1;
                        r_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_fire) begin
                        r_first <= 1'b0;
                        r_err   <= s_tuser_i[r_gnt] & ~r_first;
                        if (s_tlast_i[r_gnt]) begin
                            if (r_line == LCW'(FRAME_H - 1)) begin
                                r_line   <= '0;
                                r_state  <= ARB_IDLE;
                                r_rr_ptr <= (r_gnt == ID_W'(N_SRC - 1)) ? '0 : r_gnt + ID_W'(1);
                            end else begin
                                r_line <= r_line + LCW'(1);
                            end
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_arb.sv
// Scoreboard bench for conv_frame_arb: frame-level round-robin reference model.
module tb_conv_frame_arb;
    import conv_pkg::*;

    localparam int N  = 4;
    localparam int FH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
        logic [1:0] id;
    } exp_t;

    logic         clk;
    logic         arst_n;
    logic [N-1:0] s_tvalid;
    pixel_t       s_tdata [N];
    logic [N-1:0] s_tlast;
    logic [N-1:0] s_tuser;
    logic [N-1:0] s_tready;
    logic         m_tvalid;
    pixel_t       m_tdata;
    logic         m_tlast;
    logic         m_tuser;
    logic         m_tready;
    logic [1:0]   m_tid;
    logic         busy;
    logic         drop;
    logic         err_sof;

    conv_frame_arb #(
        .N_SRC   (N),
        .FRAME_H (FH)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .s_tvalid_i (s_tvalid),
        .s_tdata_i  (s_tdata),
        .s_tlast_i  (s_tlast),
        .s_tuser_i  (s_tuser),
        .s_tready_o (s_tready),
        .m_tvalid_o (m_tvalid),
        .m_tdata_o  (m_tdata),
        .m_tlast_o  (m_tlast),
        .m_tuser_o  (m_tuser),
        .m_tready_i (m_tready),
        .m_tid_o    (m_tid),
        .busy_o     (busy),
        .drop_o     (drop),
        .err_sof_o  (err_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t srcq [N][$];
    beat_t mq   [N][$];
    exp_t  expq [$];

    int n_chk = 0;
    int n_pass = 0;
    int ptr_m = 0;
    int last_tid = 0;
    int exp_drop = 0, drop_seen = 0;
    int exp_err = 0, err_seen = 0;
    int lines_seen = 0;
    bit vgap = 0;
    bit rdy_rand = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Source drivers: SOF heads are always offered so every pending source competes at arbitration.
    initial begin
        logic [N-1:0] fire_s;
        beat_t b;
        s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
        for (int i = 0; i < N; i++) s_tdata[i] = '0;
        forever begin
            @(negedge clk);
            fire_s = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    s_tvalid[i] = b.u ? 1'b1 : (!vgap || $urandom_range(0, 3) != 0);
                    s_tdata[i]  = b.d;
                    s_tlast[i]  = b.l;
                    s_tuser[i]  = b.u;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                    s_tuser[i]  = 1'b0;
                end
            end
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares each forwarded beat against the scoreboard.
    initial begin
        exp_t e;
        logic [N-1:0] others;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (m_tvalid && m_tready) begin
                    if (expq.size() == 0) begin
                        chk(1'b0, "unexpected_beat", {m_tdata, m_tlast, m_tuser, m_tid}, 0);
                    end else begin
                        e = expq.pop_front();
                        chk({m_tdata, m_tlast, m_tuser, m_tid} == e, "beat",
                            {m_tdata, m_tlast, m_tuser, m_tid}, e);
                        if (e.l) lines_seen++;
                    end
                end
                if (busy) begin
                    others = s_tready & ~(4'b0001 << m_tid);
                    chk(others == '0, "ready_isolation", others, 0);
                end
                if (drop) drop_seen++;
                if (err_sof) err_seen++;
            end
        end
    end

    task automatic gen_frame(input int s, input int plen, input int err_beat);
        beat_t b;
        int len, idx;
        idx = 0;
        for (int ln = 0; ln < FH; ln++) begin
            len = (plen > 0) ? plen : $urandom_range(1, 8);
            for (int p = 0; p < len; p++) begin
                b.d = 8'($urandom);
                b.l = (p == len - 1);
                b.u = (idx == 0) || (idx == err_beat);
                srcq[s].push_back(b);
                mq[s].push_back(b);
                idx++;
            end
        end
    endtask

    // Reference: serve whole frames, picking the first pending source at or after the pointer.
    task automatic plan();
        int s, c, lines;
        bit found, first;
        beat_t b;
        forever begin
            found = 0;
            s = 0;
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (!found && mq[c].size() > 0) begin
                    s = c;
                    found = 1;
                end
            end
            if (!found) break;
            lines = 0;
            first = 1;
            while (lines < FH && mq[s].size() > 0) begin
                b = mq[s].pop_front();
                if (b.u && !first) exp_err++;
                first = 0;
                expq.push_back({b.d, b.l, b.u, 2'(s)});
                if (b.l) lines++;
            end
            ptr_m = (s + 1) % N;
            last_tid = s;
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = (expq.size() == 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic wait_drain(input string nm);
        int cyc;
        cyc = 0;
        while (cyc < 20000 && !(all_empty() && !busy)) begin
            @(negedge clk);
            cyc++;
        end
        chk(cyc < 20000, {nm, "_drain_timeout"}, cyc, 20000);
        @(negedge clk);
        chk(busy == 1'b0, {nm, "_busy_after"}, busy, 0);
        chk(m_tid == 2'(last_tid), {nm, "_tid_hold"}, m_tid, last_tid);
        chk(drop_seen == exp_drop, {nm, "_drop_count"}, drop_seen, exp_drop);
        chk(err_seen == exp_err, {nm, "_err_count"}, err_seen, exp_err);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        chk({s_tready, m_tvalid, busy, drop, err_sof, m_tid} == '0, {nm, "_reset_outputs"},
            {s_tready, m_tvalid, busy, drop, err_sof, m_tid}, 0);
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        expq.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        ptr_m = 0;
        last_tid = 0;
    endtask

    initial begin
        int cyc;
        beat_t lone;
        arst_n = 1'b0;
        #1;
        chk({s_tready, m_tvalid, busy, drop, err_sof, m_tid} == '0, "initial_reset",
            {s_tready, m_tvalid, busy, drop, err_sof, m_tid}, 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame from src2, grant one cycle after SOF appears
        gen_frame(2, 8, -1);
        plan();
        @(negedge clk);
        chk(busy == 1'b0, "t1_not_yet_granted", busy, 0);
        @(negedge clk);
        chk({busy, m_tid} == {1'b1, 2'd2}, "t1_grant", {busy, m_tid}, {1'b1, 2'd2});
        wait_drain("t1");

        // 2: three simultaneous requesters, two rounds after a fresh pointer
        do_reset("t2");
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            gen_frame(0, 3, -1);
            gen_frame(1, 2, -1);
            gen_frame(3, 4, -1);
        end
        plan();
        wait_drain("t2");

        // 3: stray non-SOF beat in IDLE is dropped, then SOF granted
        @(negedge clk);
        lone.d = 8'h55; lone.l = 1'b0; lone.u = 1'b0;
        srcq[1].push_back(lone);
        exp_drop++;
        gen_frame(1, 5, -1);
        plan();
        wait_drain("t3");

        // 4: backpressure and valid gaps on src0
        @(negedge clk);
        vgap = 1; rdy_rand = 1;
        gen_frame(0, 8, -1);
        plan();
        wait_drain("t4");

        // randomized multi-source rounds
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            rdy_rand = 1'($urandom_range(0, 1));
            for (int s = 0; s < N; s++) begin
                int nf;
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) gen_frame(s, 0, -1);
            end
            plan();
            wait_drain("rand");
        end
        vgap = 0; rdy_rand = 0;

        // 5: spurious SOF on beat 5 of a src0 frame
        @(negedge clk);
        gen_frame(0, 3, 5);
        plan();
        wait_drain("t5");

        // 6: reset in the middle of a src3 frame, pointer returns to 0
        @(negedge clk);
        lines_seen = 0;
        gen_frame(3, 6, -1);
        plan();
        cyc = 0;
        while (cyc < 2000 && lines_seen < 2) begin
            @(negedge clk);
            cyc++;
        end
        chk(cyc < 2000, "t6_line_wait_timeout", cyc, 2000);
        do_reset("t6");
        @(negedge clk);
        gen_frame(1, 2, -1);
        gen_frame(0, 2, -1);
        plan();
        wait_drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
